// File: rtl/gpu_isa_pkg.sv
// gpu_isa_pkg: instruction word layout, opcode classes and issue FSM states
package gpu_isa_pkg;
   localparam int INSTR_W = 143;
   localparam int OPC_HI = 142;
   localparam int OPC_LO = 137;
   localparam int M1_HI = 136;
   localparam int M1_LO = 133;
   localparam int M2_HI = 132;
   localparam int M2_LO = 128;
   localparam int OP1_HI = 127;
   localparam int OP1_LO = 64;
   localparam int OP2_HI = 63;
   localparam int OP2_LO = 0;
   localparam logic [5:0] ALU_LAST = 6'd13;
   localparam logic [5:0] MEM_LAST = 6'd22;
   localparam logic [5:0] CTRL_LAST = 6'd27;
   localparam logic [5:0] OP_EXIT = 6'd63;
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE, S_ERR} state_e;
   function automatic logic is_illegal(input logic [5:0] op);
      return op > CTRL_LAST && op != OP_EXIT;
   endfunction
   function automatic logic is_stop(input logic [5:0] op);
      return op == OP_EXIT || is_illegal(op);
   endfunction
endpackage

// File: rtl/gpu_inst_buf.sv
// gpu_inst_buf: synchronous FIFO of {pc, word} with flush, count and head outputs
module gpu_inst_buf #(
   parameter int W = 8,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [W-1:0]             data_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic [W-1:0]             head_o
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem_q [DEPTH];
   logic [AW-1:0] rd_q, wr_q;
   logic [AW:0] cnt_q;
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         rd_q <= '0;
         wr_q <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + AW'(1);
         if (pop_i) rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
      end
   end
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_q] <= data_i;
   end
   assign count_o = cnt_q;
   assign head_o = mem_q[rd_q];
endmodule

// File: rtl/gpu_inst_issue.sv
// gpu_inst_issue: instruction fetch/issue front end feeding gpu_warp over valid/ready
module gpu_inst_issue #(
   parameter int PC_W = 4,
   parameter int INSTR_W = gpu_isa_pkg::INSTR_W,
   parameter int BUF_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [PC_W-1:0]    start_pc,
   output logic               imem_en,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               inst_valid,
   input  logic               inst_ready,
   output logic [5:0]         inst_opcode,
   output logic [3:0]         inst_mode1,
   output logic [4:0]         inst_mode2,
   output logic [63:0]        inst_op1,
   output logic [63:0]        inst_op2,
   output logic [PC_W-1:0]    inst_pc,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               busy,
   output logic               done,
   output logic               illegal
);
   import gpu_isa_pkg::*;
   localparam int CW = $clog2(BUF_DEPTH) + 1;
   state_e state_q;
   logic [PC_W-1:0] pc_q, infl_pc_q, hpc;
   logic inflight_q, tag_q, epoch_q, done_q, illegal_q;
   logic [CW-1:0] count;
   logic [PC_W+INSTR_W-1:0] head;
   logic [INSTR_W-1:0] hword;
   logic [5:0] hop;
   logic active, start_ok, redir_ok, hs, head_ill, exit_hs, push, flush, word_stop;
   logic [CW:0] used, limit;
   assign {hpc, hword} = head;
   assign hop = hword[OPC_HI:OPC_LO];
   assign active = state_q == S_FETCH || state_q == S_DRAIN;
   assign start_ok = start && !active;
   assign redir_ok = redirect_valid && active;
   assign head_ill = active && count != '0 && is_illegal(hop);
   assign inst_valid = active && count != '0 && !is_illegal(hop);
   assign hs = inst_valid && inst_ready;
   assign exit_hs = hs && hop == OP_EXIT;
   assign push = inflight_q && tag_q == epoch_q && state_q == S_FETCH && !redir_ok;
   assign flush = start_ok || redir_ok || exit_hs;
   assign word_stop = push && is_stop(imem_rdata[OPC_HI:OPC_LO]);
   // the slot freed by this cycle's pop is credited so a full stream sustains one per cycle
   assign used = {1'b0, count} + {{CW{1'b0}}, inflight_q};
   assign limit = (CW+1)'(BUF_DEPTH) + {{CW{1'b0}}, hs};
   assign imem_en = state_q == S_FETCH && !redir_ok && used < limit;
   assign imem_addr = imem_en ? pc_q : '0;
   assign inst_opcode = inst_valid ? hop : '0;
   assign inst_mode1 = inst_valid ? hword[M1_HI:M1_LO] : '0;
   assign inst_mode2 = inst_valid ? hword[M2_HI:M2_LO] : '0;
   assign inst_op1 = inst_valid ? hword[OP1_HI:OP1_LO] : '0;
   assign inst_op2 = inst_valid ? hword[OP2_HI:OP2_LO] : '0;
   assign inst_pc = inst_valid ? hpc : '0;
   assign busy = active;
   assign done = done_q;
   assign illegal = illegal_q;
   gpu_inst_buf #(.W(PC_W + INSTR_W), .DEPTH(BUF_DEPTH)) u_buf (
      .clk(clk),
      .rst(rst),
      .push_i(push),
      .data_i({infl_pc_q, imem_rdata}),
      .pop_i(hs),
      .flush_i(flush),
      .count_o(count),
      .head_o(head)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q <= '0;
         infl_pc_q <= '0;
         inflight_q <= 1'b0;
         tag_q <= 1'b0;
         epoch_q <= 1'b0;
         done_q <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         inflight_q <= imem_en;
         tag_q <= epoch_q;
         infl_pc_q <= pc_q;
         if (imem_en) pc_q <= pc_q + PC_W'(1);
         if (start_ok) begin
            state_q <= S_FETCH;
            pc_q <= start_pc;
            done_q <= 1'b0;
            illegal_q <= 1'b0;
         end else if (redir_ok) begin
            state_q <= S_FETCH;
            pc_q <= redirect_pc;
            epoch_q <= ~epoch_q;
         end else if (exit_hs) begin
            state_q <= S_DONE;
            done_q <= 1'b1;
         end else if (head_ill) begin
            state_q <= S_ERR;
            illegal_q <= 1'b1;
         end else if (word_stop) begin
            state_q <= S_DRAIN;
         end
      end
   end
endmodule

// File: doc/gpu_inst_issue.md
Name: gpu_inst_issue

Overview:
Instruction fetch/issue front end that feeds gpu_warp: on start it reads 143-bit instruction words from a synchronous instruction memory and buffers them. It presents the decoded fields to the warp over a valid/ready handshake. It tracks the PC, honours branch redirects from the warp, and stops on EXIT or on an illegal opcode. It is the producer end of the warp's instruction interface, replacing the warp's private instruction file.

Parameters:
PC_W, 4, PC / instruction-memory address width (2^PC_W words)
INSTR_W, 143, instruction word width; fixed layout below
BUF_DEPTH, 2, issue buffer entries (power of two, >=2)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-high reset
start  in  1  pulse: begin fetching at start_pc (ignored unless IDLE, DONE or ERR)
start_pc  in  PC_W  first PC
imem_en  out  1  read strobe to instruction memory
imem_addr  out  PC_W  read address
imem_rdata  in  INSTR_W  read data, valid exactly 1 cycle after imem_en
inst_valid  out  1  decoded instruction available
inst_ready  in  1  warp accepts the instruction
inst_opcode  out  6  word[142:137]
inst_mode1  out  4  word[136:133], operand-1 mode
inst_mode2  out  5  word[132:128], operand-2 mode
inst_op1  out  64  word[127:64]
inst_op2  out  64  word[63:0]
inst_pc  out  PC_W  PC of the presented instruction
redirect_valid  in  1  warp branch taken
redirect_pc  in  PC_W  branch target
busy  out  1  state is FETCH or DRAIN
done  out  1  level; EXIT instruction accepted by warp
illegal  out  1  level; illegal opcode reached buffer head

Behaviour:
- Reset values: all outputs 0; state IDLE; pc 0; buffer empty; in-flight 0; epoch 0.
- States: IDLE -start-> FETCH; FETCH -EXIT or illegal word buffered-> DRAIN; DRAIN -EXIT handshake-> DONE; DRAIN/FETCH -illegal at head-> ERR; DONE/ERR -start-> FETCH. start clears done and illegal, flushes the buffer, and loads pc from start_pc.
- Opcode classes: 0-13 ALU, 14-22 memory, 23-27 control, 63 EXIT. 28-62 are illegal.
- Fetch: in FETCH, imem_en=1 and imem_addr=pc whenever occupancy + inflight < BUF_DEPTH. pc increments modulo 2^PC_W; wrap from 2^PC_W-1 to 0 is legal and is not an error.
- Response: one cycle later the word is written to the buffer tail with its PC, unless its epoch tag differs from the current epoch. A mismatched word is dropped.
- Throughput: one instruction per cycle sustained with inst_ready held high; first inst_valid 2 cycles after start.
- Buffered EXIT or illegal word: fetching stops; no further imem_en until the next start.
- Head presentation: the head is presented with inst_valid=1 unless its opcode is illegal. An illegal head gives inst_valid=0, illegal=1, and state ERR.
- Output stability: outputs hold stable while inst_valid && !inst_ready.
- Handshake: a transfer occurs when inst_valid && inst_ready, and pops the head.
- Redirect: takes effect on the cycle redirect_valid=1 in FETCH or DRAIN.
  - A handshake in the same cycle completes first.
  - Then the buffer is flushed, epoch toggles (in-flight read discarded), pc <= redirect_pc, and state returns to FETCH.
  - inst_valid is 0 the next cycle.
  - Redirect is ignored in IDLE, DONE and ERR.
- Simultaneous start and redirect: start wins.
- Reset mid-operation: returns to the reset values in one cycle, and any in-flight response is ignored.

Decomposition:
- Shared package gpu_isa_pkg: INSTR_W and field bit positions; opcode class bounds (ALU_LAST=13, MEM_LAST=22, CTRL_LAST=27, OP_EXIT=63); state enum; function is_illegal(opcode).
- One sub-module: gpu_inst_buf, a synchronous FIFO of {pc, word} with push, pop, flush, count, and head outputs.

Test Plan:
- Straight line: imem holds ALU ops at 0..3 and EXIT at 4, start_pc=0, ready=1. Required: inst_pc 0,1,2,3,4 on consecutive cycles, first valid 2 cycles after start; done=1 the cycle after PC 4 is accepted; imem_en never asserted for PC>=6.
- Backpressure: ready low for 5 cycles at PC 1. Required: fields frozen at PC 1, no more than 2 words buffered or in flight, no instruction lost or duplicated on release.
- Redirect: warp accepts PC 2 with redirect_valid=1, redirect_pc=9. Required: PC 2 counted once; PCs 3 and 4 (buffered or in flight) never presented; next presented inst_pc=9.
- Wrap: start_pc=14, PC_W=4, EXIT at 1. Required: sequence 14,15,0,1, then done.
- Illegal: opcode 40 at PC 3. Required: PCs 0-2 issued; then inst_valid=0, illegal=1, busy=0; a later start at PC 5 clears illegal.
- Reset mid-run: rst asserted for 1 cycle while 2 entries are buffered and 1 read is in flight. Required: all outputs 0 the next cycle; the stale imem_rdata is not pushed.
